tile_match_controller: RTL and testbench
========================================

Name: tile_match_controller

Overview:
In-game sequencer for the 10-tile matching game. It takes switch flips as tile selections, reveals two tiles at a time and blinks them for a fixed reveal window. It then compares their colours, updates the matched mask, counts moves and flags game over. It sits between the board I/O (SW, LEDR, HEX) and the top-level mode FSM, which drives start/quit and consumes game_over.

Parameters:
TILE_COLORS, 30'b101_101_001_011_100_010_100_011_010_001, 3-bit colour per tile; tile i at [3i+2:3i] (pairs 0/7, 1/4, 2/6, 3/5, 8/9)
REVEAL_CYCLES, 50_000_000, length of the reveal window in clocks (1 s); must be ≥2
BLINK_DIV, 12_500_000, clocks per blink half-period; must be ≥1

Ports:
CLOCK_50  in  1  system clock
resetn  in  1  synchronous, active-low reset
start  in  1  single-cycle pulse from the mode FSM: begin a new game
quit  in  1  level: abandon the game
SW  in  10  tile switches, asynchronous
led  out  10  tile LEDs
hex_a  out  4  colour of first selected tile (zero-extended)
hex_b  out  4  colour of second selected tile
hex_a_valid  out  1  hex_a is meaningful
hex_b_valid  out  1  hex_b is meaningful
matched  out  10  tiles already matched
move_count  out  8  completed pair attempts
game_over  out  1  all 10 tiles matched
state  out  3  IDLE=0, PICK1=1, PICK2=2, REVEAL=3, DONE=4

Behaviour:
- Reset: state=IDLE. All outputs 0. Internal selections, timers, blink phase and sync registers are cleared.
- SW path: 2-flop synchroniser s1→s2, then history register s3. rise[i]=s2[i]&~s3[i].
  - An SW change set up before edge k produces a state update at edge k+2.
  - The synchroniser and history registers update in every state, so no stale edges are kept.
- Valid pick: rise[i] with matched[i]=0 and i≠first_idx. If several are valid in one cycle, the lowest index wins and the rest are discarded.
- IDLE:
  - start → PICK1.
  - Clear matched, move_count, selections and game_over.
- PICK1: valid pick i → first_idx=i, hex_a=colour(i), hex_a_valid=1, go to PICK2.
- PICK2: valid pick j → second_idx=j, hex_b=colour(j), hex_b_valid=1.
  - move_count++ (saturates at 255).
  - timer=REVEAL_CYCLES-1, blink phase=1, blink counter=BLINK_DIV-1.
  - Go to REVEAL.
- REVEAL:
  - The timer decrements each cycle.
  - The blink counter decrements; at 0 it reloads and the phase toggles.
  - All SW edges are ignored.
  - At timer==0 (REVEAL lasts exactly REVEAL_CYCLES cycles):
    - colours equal → matched |= both bits. If the result is 10'h3FF → DONE and game_over=1; otherwise → PICK1.
    - colours differ → PICK1, matched unchanged.
    - Either way, hex_a_valid and hex_b_valid clear and both hex values go to 0.
- DONE:
  - game_over=1 is held.
  - start → same clearing as IDLE+start, then PICK1 with game_over=0.
- LEDs: led = matched OR overlay, where the overlay is:
  - PICK2: bit first_idx = 1.
  - REVEAL: bits first_idx and second_idx = blink phase.
  - Other states: no overlay.
- quit:
  - In any state other than IDLE: next state is IDLE.
  - matched, selections, hex outputs/valids and game_over clear.
  - move_count holds its value until the next start.
- Priority: resetn > quit > start > timer expiry / pick.
- start in PICK1, PICK2 or REVEAL is ignored.
- Width rules: colours compare as full 3-bit values; colour 0 is a legal colour.

Test Plan (REVEAL_CYCLES=8, BLINK_DIV=2):
1. Reset mid-REVEAL:
   - Stimulus: resetn=0 for 1 cycle.
   - Required: the next cycle shows state=0, led=0, matched=0, move_count=0, game_over=0.
2. Matching pair:
   - Stimulus: start, raise SW[0], then raise SW[7].
   - Required: state=3 for exactly 8 cycles, with led[0] and led[7] toggling every 2 cycles starting at 1.
   - Required: then matched=10'h081, led=10'h081, move_count=1, state=1.
3. Mismatch:
   - Stimulus: picks of SW[1] then SW[2].
   - Required: after the reveal, matched is unchanged and led[1] and led[2] are 0.
   - Required: hex_a=2 and hex_b=3 during the reveal; move_count increments.
4. Illegal picks:
   - Stimulus: re-raise an already matched SW[0]; raise SW[3] twice in PICK1/PICK2; raise SW[3] and SW[5] in the same cycle.
   - Required: matched tiles and the duplicate are ignored; the same-cycle case selects tile 3 only.
5. Full game:
   - Stimulus: play all 5 correct pairs.
   - Required: game_over=1, state=4, matched=10'h3FF, move_count=5.
   - Stimulus: then start.
   - Required: state=1, matched=0, move_count=0.
6. quit during PICK2:
   - Required: state=0, led=0, hex_a_valid=0, move_count holds its value.
   - Stimulus: quit and start asserted together.
   - Required: quit wins.

Source files
------------

// File: rtl/tile_match_controller_if.sv
// tile_match_controller_if
//   Board-side bundle between the mode FSM / board I/O and the in-game sequencer.
//   master : mode FSM + board inputs (drives start, quit, SW; observes the rest)
//   slave  : tile_match_controller (consumes start, quit, SW; drives the rest)
//   start        1   single-cycle pulse: begin a new game
//   quit         1   level: abandon the game
//   SW           10  tile switches (asynchronous)
//   led          10  tile LEDs
//   hex_a/hex_b  4   colours of the first/second selected tile
//   hex_*_valid  1   the matching hex value is meaningful
//   matched      10  tiles already matched
//   move_count   8   completed pair attempts
//   game_over    1   all tiles matched
//   state        3   IDLE=0, PICK1=1, PICK2=2, REVEAL=3, DONE=4
interface tile_match_controller_if;
    logic       start;
    logic       quit;
    logic [9:0] SW;
    logic [9:0] led;
    logic [3:0] hex_a;
    logic [3:0] hex_b;
    logic       hex_a_valid;
    logic       hex_b_valid;
    logic [9:0] matched;
    logic [7:0] move_count;
    logic       game_over;
    logic [2:0] state;

    modport master (
        output start, quit, SW,
        input  led, hex_a, hex_b, hex_a_valid, hex_b_valid,
               matched, move_count, game_over, state
    );

    modport slave (
        input  start, quit, SW,
        output led, hex_a, hex_b, hex_a_valid, hex_b_valid,
               matched, move_count, game_over, state
    );
endinterface

// File: rtl/tile_match_controller.sv
// tile_match_controller
//   In-game sequencer for the 10-tile matching game: turns switch flips into
//   tile picks, reveals a pair with blinking LEDs for a fixed window, then
//   compares colours, updates the matched mask, counts moves, flags game over.
//   CLOCK_50 : system clock
//   resetn   : synchronous, active-low reset
//   bus      : tile_match_controller_if.slave (start/quit/SW in, board outputs out)
module tile_match_controller #(
    parameter logic [29:0] TILE_COLORS   = 30'b101_101_001_011_100_010_100_011_010_001,
    parameter int unsigned REVEAL_CYCLES = 50_000_000,
    parameter int unsigned BLINK_DIV     = 12_500_000
) (
    input logic                    CLOCK_50,
    input logic                    resetn,
    tile_match_controller_if.slave bus
);
    localparam int unsigned TW = (REVEAL_CYCLES > 2) ? $clog2(REVEAL_CYCLES) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PICK1  = 3'd1,
        PICK2  = 3'd2,
        REVEAL = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t        r_state;
    logic [9:0]    r_s1, r_s2, r_s3;
    logic [9:0]    r_matched;
    logic [3:0]    r_first_idx, r_second_idx;
    logic [3:0]    r_hex_a, r_hex_b;
    logic          r_hex_a_valid, r_hex_b_valid;
    logic [7:0]    r_move_count;
    logic          r_game_over;
    logic [TW-1:0] r_timer;
    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;

    logic [9:0]    w_rise, w_valid, w_first_oh, w_second_oh, w_pair_matched, w_led;
    logic          w_pick_any;
    logic [3:0]    w_pick_idx;

    function automatic logic [3:0] colour(input logic [3:0] idx);
        logic [3:0] c;
        c = '0;
        for (int unsigned t = 0; t < 10; t++) begin
            if (idx == 4'(t)) c = {1'b0, TILE_COLORS[3*t +: 3]};
        end
        return c;
    endfunction

    always_comb begin
        w_first_oh  = '0;
        w_second_oh = '0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (r_first_idx  == 4'(i)) w_first_oh[i]  = 1'b1;
            if (r_second_idx == 4'(i)) w_second_oh[i] = 1'b1;
        end
    end

    // The "differs from first pick" exclusion only matters while a first pick is held.
    assign w_rise  = r_s2 & ~r_s3;
    assign w_valid = w_rise & ~r_matched & ((r_state == PICK2) ? ~w_first_oh : '1);
    assign w_pair_matched = r_matched | w_first_oh | w_second_oh;

    // Descending scan so the lowest valid index is the one left standing.
    always_comb begin
        w_pick_idx = '0;
        for (int unsigned i = 10; i > 0; i--) begin
            if (w_valid[i-1]) w_pick_idx = 4'(i-1);
        end
    end
    assign w_pick_any = |w_valid;

    always_comb begin
        w_led = r_matched;
        if (r_state == PICK2)
            w_led = r_matched | w_first_oh;
        else if (r_state == REVEAL && r_blink_phase)
            w_led = r_matched | w_first_oh | w_second_oh;
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_state       <= IDLE;
            r_s1          <= '0;
            r_s2          <= '0;
            r_s3          <= '0;
            r_matched     <= '0;
            r_first_idx   <= '0;
            r_second_idx  <= '0;
            r_hex_a       <= '0;
            r_hex_b       <= '0;
            r_hex_a_valid <= 1'b0;
            r_hex_b_valid <= 1'b0;
            r_move_count  <= '0;
            r_game_over   <= 1'b0;
            r_timer       <= '0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else begin
            r_s1 <= bus.SW;
            r_s2 <= r_s1;
            r_s3 <= r_s2;

            if (bus.quit) begin
                // move_count deliberately survives a quit until the next start
                r_state       <= IDLE;
                r_matched     <= '0;
                r_first_idx   <= '0;
                r_second_idx  <= '0;
                r_hex_a       <= '0;
                r_hex_b       <= '0;
                r_hex_a_valid <= 1'b0;
                r_hex_b_valid <= 1'b0;
                r_game_over   <= 1'b0;
                r_timer       <= '0;
                r_blink_cnt   <= '0;
                r_blink_phase <= 1'b0;
            end else if (bus.start && (r_state == IDLE || r_state == DONE)) begin
                r_state       <= PICK1;
                r_matched     <= '0;
                r_first_idx   <= '0;
                r_second_idx  <= '0;
                r_hex_a       <= '0;
                r_hex_b       <= '0;
                r_hex_a_valid <= 1'b0;
                r_hex_b_valid <= 1'b0;
                r_move_count  <= '0;
                r_game_over   <= 1'b0;
            end else begin
                case (r_state)
                    PICK1: begin
                        if (w_pick_any) begin
                            r_first_idx   <= w_pick_idx;
                            r_hex_a       <= colour(w_pick_idx);
                            r_hex_a_valid <= 1'b1;
                            r_state       <= PICK2;
                        end
                    end
                    PICK2: begin
                        if (w_pick_any) begin
                            r_second_idx  <= w_pick_idx;
                            r_hex_b       <= colour(w_pick_idx);
                            r_hex_b_valid <= 1'b1;
                            if (r_move_count != 8'hFF) r_move_count <= r_move_count + 8'd1;
                            r_timer       <= TW'(REVEAL_CYCLES - 1);
                            r_blink_cnt   <= BW'(BLINK_DIV - 1);
                            r_blink_phase <= 1'b1;
                            r_state       <= REVEAL;
                        end
                    end
                    REVEAL: begin
                        if (r_blink_cnt == '0) begin
                            r_blink_cnt   <= BW'(BLINK_DIV - 1);
                            r_blink_phase <= ~r_blink_phase;
                        end else begin
                            r_blink_cnt <= r_blink_cnt - BW'(1);
                        end
                        if (r_timer == '0) begin
                            r_hex_a       <= '0;
                            r_hex_b       <= '0;
                            r_hex_a_valid <= 1'b0;
                            r_hex_b_valid <= 1'b0;
                            r_state       <= PICK1;
                            // hex registers still hold the zero-extended colours here
                            if (r_hex_a == r_hex_b) begin
                                r_matched <= w_pair_matched;
                                if (w_pair_matched == '1) begin
                                    r_state     <= DONE;
                                    r_game_over <= 1'b1;
                                end
                            end
                        end else begin
                            r_timer <= r_timer - TW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.led         = w_led;
    assign bus.hex_a       = r_hex_a;
    assign bus.hex_b       = r_hex_b;
    assign bus.hex_a_valid = r_hex_a_valid;
    assign bus.hex_b_valid = r_hex_b_valid;
    assign bus.matched     = r_matched;
    assign bus.move_count  = r_move_count;
    assign bus.game_over   = r_game_over;
    assign bus.state       = r_state;
endmodule

// File: tb/tb_tile_match_controller.sv
// tb_tile_match_controller
//   Randomised scoreboard bench for tile_match_controller (REVEAL_CYCLES=8, BLINK_DIV=2).
//   Stimulus updates a game-level model and queues the expected board snapshot for
//   every state change; a monitor pops and compares whenever the DUT state moves,
//   and checks the blink pattern on every reveal cycle.
module tb_tile_match_controller;
    localparam int RC = 8;
    localparam int BD = 2;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    tile_match_controller_if bus();

    tile_match_controller #(.REVEAL_CYCLES(RC), .BLINK_DIV(BD)) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .bus      (bus)
    );

    typedef struct {
        int st; int matched; int mc; int go;
        int ha; int hb; int hav; int hbv; int led;
        int rlen; int fi; int si;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   COL[10] = '{1, 2, 3, 4, 2, 4, 3, 1, 5, 5};

    // game-level model
    bit m_in_game = 0;
    bit m_over    = 0;
    int m_first   = -1;
    int m_matched = 0;
    int m_mc      = 0;

    task automatic chk(input string name, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
        end
    endtask

    function automatic exp_t snap(input int ha, input int hb, input int hav, input int hbv,
                                  input int fi, input int si, input bit rev);
        exp_t e;
        if (!m_in_game)      e.st = 0;
        else if (m_over)     e.st = 4;
        else if (rev)        e.st = 3;
        else if (m_first >= 0) e.st = 2;
        else                 e.st = 1;
        e.matched = m_matched;
        e.mc  = m_mc;
        e.go  = m_over ? 1 : 0;
        e.ha  = ha; e.hb = hb; e.hav = hav; e.hbv = hbv;
        e.fi  = fi; e.si = si;
        e.rlen = RC;
        e.led = m_matched;
        if (e.st == 2) e.led = m_matched | (1 << fi);
        if (e.st == 3) e.led = m_matched | (1 << fi) | (1 << si);
        return e;
    endfunction

    // ---------------- monitor ----------------
    int   prev_st = 7;
    int   rcnt = 0;
    exp_t mon_e, mon_cur;

    initial begin
        forever begin
            @(posedge clk); #1;
            if (int'(bus.state) != prev_st) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_event: state went to %0d, expected no change (t=%0t)",
                             bus.state, $time);
                end else begin
                    mon_e = q.pop_front();
                    if (prev_st == 3 && mon_e.rlen >= 0) chk("reveal_len", rcnt, mon_e.rlen);
                    chk("state",       int'(bus.state),       mon_e.st);
                    chk("matched",     int'(bus.matched),     mon_e.matched);
                    chk("move_count",  int'(bus.move_count),  mon_e.mc);
                    chk("game_over",   int'(bus.game_over),   mon_e.go);
                    chk("hex_a",       int'(bus.hex_a),       mon_e.ha);
                    chk("hex_b",       int'(bus.hex_b),       mon_e.hb);
                    chk("hex_a_valid", int'(bus.hex_a_valid), mon_e.hav);
                    chk("hex_b_valid", int'(bus.hex_b_valid), mon_e.hbv);
                    chk("led",         int'(bus.led),         mon_e.led);
                    if (mon_e.st == 3) mon_cur = mon_e;
                end
                rcnt = 0;
                prev_st = int'(bus.state);
            end
            if (int'(bus.state) == 3) begin
                // blink phase is "on" for the first BD cycles, then alternates every BD cycles
                chk("reveal_led", int'(bus.led),
                    mon_cur.matched | ((((rcnt / BD) % 2) == 0) ? ((1 << mon_cur.fi) | (1 << mon_cur.si)) : 0));
                rcnt++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete, errors=%0d", errors);
        $fatal(1, "timeout");
    end

    // ---------------- stimulus ----------------
    task automatic do_start();
        if (!m_in_game || m_over) begin
            m_in_game = 1; m_over = 0; m_matched = 0; m_mc = 0; m_first = -1;
            q.push_back(snap(0, 0, 0, 0, -1, -1, 0));
        end
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic do_pick(input logic [9:0] mask, input bit noise);
        int chosen = -1;
        bit rev = 0;
        int n;
        if (m_in_game && !m_over) begin
            for (int i = 0; i < 10; i++)
                if (chosen < 0 && mask[i] && ((m_matched >> i) & 1) == 0 && !(m_first >= 0 && i == m_first))
                    chosen = i;
        end
        if (chosen >= 0) begin
            if (m_first < 0) begin
                m_first = chosen;
                q.push_back(snap(COL[chosen], 0, 1, 0, chosen, -1, 0));
            end else begin
                int f = m_first;
                m_mc = (m_mc < 255) ? m_mc + 1 : 255;
                q.push_back(snap(COL[f], COL[chosen], 1, 1, f, chosen, 1));
                if (COL[f] == COL[chosen]) m_matched = m_matched | (1 << f) | (1 << chosen);
                m_first = -1;
                if (m_matched == 10'h3FF) m_over = 1;
                q.push_back(snap(0, 0, 0, 0, -1, -1, 0));
                rev = 1;
            end
        end
        @(negedge clk) bus.SW = bus.SW | mask;
        repeat (3) @(negedge clk);
        @(negedge clk);
        if (rev && noise) begin
            // a flip landing mid-reveal must be ignored
            n = $urandom_range(0, 9);
            for (int k = 0; k < 10 && mask[n]; k++) n = (n + 1) % 10;
            bus.SW[n] = 1'b1;
        end
        @(negedge clk) bus.SW = '0;
        if (rev) repeat (RC + 2) @(negedge clk);
        else     repeat (2) @(negedge clk);
    endtask

    initial begin
        int pa[5] = '{0, 1, 2, 3, 8};
        int pb[5] = '{7, 4, 6, 5, 9};
        int tmp, j;
        logic [9:0] mask;

        bus.start = 1'b0;
        bus.quit  = 1'b0;
        bus.SW    = '0;
        q.push_back(snap(0, 0, 0, 0, -1, -1, 0));
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // matching pair, mismatch, illegal picks
        do_start();
        do_pick(10'(1 << 0), 0);
        do_pick(10'(1 << 7), 1);
        chk("pair_matched", int'(bus.matched), 10'h081);
        do_pick(10'(1 << 1), 0);
        do_pick(10'(1 << 2), 1);
        do_pick(10'(1 << 0), 0);                 // already matched
        do_pick(10'((1 << 3) | (1 << 5)), 0);    // same cycle: 3 wins
        do_pick(10'(1 << 3), 0);                 // duplicate of first pick
        do_pick(10'(1 << 5), 0);
        chk("after_illegal_matched", int'(bus.matched), m_matched);

        // reset in the middle of a reveal
        do_pick(10'(1 << 1), 0);
        m_mc++;
        q.push_back(snap(COL[1], COL[4], 1, 1, 1, 4, 1));
        @(negedge clk) bus.SW[4] = 1'b1;
        repeat (5) @(negedge clk);
        bus.SW = '0;
        m_in_game = 0; m_over = 0; m_matched = 0; m_mc = 0; m_first = -1;
        begin
            exp_t r;
            r = snap(0, 0, 0, 0, -1, -1, 0);
            r.rlen = -1;
            q.push_back(r);
        end
        resetn = 1'b0;
        @(negedge clk) resetn = 1'b1;
        repeat (3) @(negedge clk);

        // full game with random pair order
        do_start();
        for (int i = 4; i > 0; i--) begin
            j = $urandom_range(0, i);
            tmp = pa[i]; pa[i] = pa[j]; pa[j] = tmp;
            tmp = pb[i]; pb[i] = pb[j]; pb[j] = tmp;
        end
        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                do_pick(10'(1 << pa[i]), 0);
                do_pick(10'(1 << pb[i]), 1);
            end else begin
                do_pick(10'(1 << pb[i]), 0);
                do_pick(10'(1 << pa[i]), 1);
            end
        end
        chk("full_game_moves", int'(bus.move_count), 5);
        do_start();

        // random play
        for (int it = 0; it < 40; it++) begin
            if (!m_in_game || m_over) do_start();
            if ($urandom_range(0, 7) == 0) do_start();   // ignored mid-game
            mask = 10'(1 << $urandom_range(0, 9));
            if ($urandom_range(0, 3) == 0) mask = mask | 10'(1 << $urandom_range(0, 9));
            do_pick(mask, 1);
        end

        // quit in PICK2 with start asserted alongside
        if (!m_in_game || m_over) do_start();
        if (m_first < 0) begin
            int u = -1;
            for (int i = 0; i < 10; i++) if (u < 0 && ((m_matched >> i) & 1) == 0) u = i;
            do_pick(10'(1 << u), 0);
        end
        m_in_game = 0; m_over = 0; m_matched = 0; m_first = -1;
        q.push_back(snap(0, 0, 0, 0, -1, -1, 0));
        @(negedge clk) begin bus.quit = 1'b1; bus.start = 1'b1; end
        @(negedge clk) begin bus.quit = 1'b0; bus.start = 1'b0; end
        repeat (4) @(negedge clk);
        chk("quit_mc_hold", int'(bus.move_count), m_mc);
        chk("quit_led", int'(bus.led), 0);
        do_start();

        repeat (RC) @(negedge clk);
        chk("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
